// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared register-bank geometry and scanner state encoding.
// Revision : 1.0
// ============================================================================
package spi_pkg;

    localparam int SPI_NREGS  = 16;
    localparam int SPI_ADDR_W = 4;
    localparam int SPI_DATA_W = 32;

    typedef enum logic [1:0] {
        SC_IDLE  = 2'd0,
        SC_READ  = 2'd1,
        SC_WRITE = 2'd2,
        SC_DONE  = 2'd3
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/scan_timer.sv
`default_nettype none
// ============================================================================
// Module   : scan_timer
// Purpose  : Free-running 0..SCAN_DIV-1 prescaler; Tick marks the last count.
// Revision : 1.0
// ============================================================================
module scan_timer #(
    parameter int SCAN_DIV = 50000
) (
    input  logic Clk,
    input  logic Reset_n,
    output logic Tick
);

    localparam int c_cnt_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(SCAN_DIV - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_cnt_w'(1);
        end
    end

    assign Tick = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/spi_reg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_scanner
// Purpose  : Periodically mirrors the mosi bank into shadow command words and
//            writes a coherent status snapshot into the miso bank.
// Revision : 1.0
// ============================================================================
module spi_reg_scanner
    import spi_pkg::*;
#(
    parameter int N_CMD    = 8,
    parameter int N_STAT   = 8,
    parameter int SCAN_DIV = 50000
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    output logic                         Data_WE,
    output logic [SPI_ADDR_W-1:0]        Data_Addr,
    output logic [SPI_DATA_W-1:0]        Data_Write,
    input  logic [SPI_DATA_W-1:0]        Data_Read,
    input  logic [N_STAT*SPI_DATA_W-1:0] Stat_In,
    input  logic                         Scan_Now,
    input  logic                         Freeze,
    output logic [N_CMD*SPI_DATA_W-1:0]  Cmd_Out,
    output logic [N_CMD-1:0]             Cmd_Update,
    output logic                         Scan_Done
);

    generate
        if (N_CMD < 1 || N_CMD > SPI_NREGS) begin : g_bad_n_cmd
            $error("spi_reg_scanner: N_CMD must be 1..16");
        end
        if (N_STAT < 1 || N_STAT > SPI_NREGS) begin : g_bad_n_stat
            $error("spi_reg_scanner: N_STAT must be 1..16");
        end
        if (SCAN_DIV < N_CMD + N_STAT + 2) begin : g_bad_scan_div
            $error("spi_reg_scanner: SCAN_DIV too small for one scan");
        end
    endgenerate

    localparam logic [SPI_ADDR_W-1:0] c_last_cmd  = SPI_ADDR_W'(N_CMD - 1);
    localparam logic [SPI_ADDR_W-1:0] c_last_stat = SPI_ADDR_W'(N_STAT - 1);

    scan_state_t           r_state;
    logic [SPI_ADDR_W-1:0] r_index;
    logic                  r_pending;
    logic                  r_we;
    logic [SPI_DATA_W-1:0] r_wdata;
    logic                  r_done;
    logic [SPI_DATA_W-1:0] r_snap [N_STAT];
    logic [SPI_DATA_W-1:0] r_cmd  [N_CMD];
    logic [N_CMD-1:0]      r_upd;

    logic                  w_tick;
    logic                  w_start;
    logic [SPI_ADDR_W-1:0] w_index_inc;
    logic [SPI_DATA_W-1:0] w_snap_next;

    scan_timer #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_timer (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Tick    (w_tick)
    );

    assign w_start     = (r_state == SC_IDLE) && r_pending && !Freeze;
    assign w_index_inc = r_index + SPI_ADDR_W'(1);

    // Next miso word is preloaded so Data_Write leaves a register, not a mux.
    always_comb begin
        w_snap_next = '0;
        for (int k = 0; k < N_STAT; k++) begin
            if (w_index_inc == SPI_ADDR_W'(k)) begin
                w_snap_next = r_snap[k];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= SC_IDLE;
            r_index   <= '0;
            r_pending <= 1'b0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // A request landing in the start cycle merges into that scan.
            if (w_start) begin
                r_pending <= 1'b0;
            end else if (w_tick || Scan_Now) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                SC_IDLE: begin
                    if (w_start) begin
                        r_state <= SC_READ;
                        r_index <= '0;
                    end
                end
                SC_READ: begin
                    if (r_index == c_last_cmd) begin
                        r_state <= SC_WRITE;
                        r_index <= '0;
                        r_we    <= 1'b1;
                        r_wdata <= r_snap[0];
                    end else begin
                        r_index <= w_index_inc;
                    end
                end
                SC_WRITE: begin
                    if (r_index == c_last_stat) begin
                        r_state <= SC_DONE;
                        r_index <= '0;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_index <= w_index_inc;
                        r_wdata <= w_snap_next;
                    end
                end
                SC_DONE: begin
                    r_state <= SC_IDLE;
                end
                default: begin
                    r_state <= SC_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < N_STAT; k++) begin
                r_snap[k] <= '0;
            end
        end else if (w_start) begin
            for (int k = 0; k < N_STAT; k++) begin
                r_snap[k] <= Stat_In[k*SPI_DATA_W +: SPI_DATA_W];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < N_CMD; k++) begin
                r_cmd[k] <= '0;
            end
            r_upd <= '0;
        end else begin
            r_upd <= '0;
            for (int k = 0; k < N_CMD; k++) begin
                if (r_state == SC_READ && r_index == SPI_ADDR_W'(k) && Data_Read != r_cmd[k]) begin
                    r_cmd[k] <= Data_Read;
                    r_upd[k] <= 1'b1;
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < N_CMD; k++) begin : g_cmd_out
            assign Cmd_Out[k*SPI_DATA_W +: SPI_DATA_W] = r_cmd[k];
        end
    endgenerate

    assign Data_WE    = r_we;
    assign Data_Addr  = r_index;
    assign Data_Write = r_wdata;
    assign Cmd_Update = r_upd;
    assign Scan_Done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_scanner
// Purpose  : Self-checking bench for spi_reg_scanner against a bank-level model.
// Revision : 1.0
// ============================================================================
module tb_spi_reg_scanner;

    localparam int N_CMD    = 8;
    localparam int N_STAT   = 8;
    localparam int SCAN_LEN = N_CMD + N_STAT + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic                   we, done, scan_now, freeze;
    logic [3:0]             addr;
    logic [31:0]            wdata, rdata;
    logic [N_STAT*32-1:0]   stat;
    logic [N_CMD*32-1:0]    cmd;
    logic [N_CMD-1:0]       upd;

    logic                   we2, done2, scan_now2, freeze2;
    logic [3:0]             addr2;
    logic [31:0]            wdata2, rdata2;
    logic [N_STAT*32-1:0]   stat2;
    logic [N_CMD*32-1:0]    cmd2;
    logic [N_CMD-1:0]       upd2;

    logic [31:0] mosi [16];
    logic [31:0] miso [16];
    logic [31:0] exp_cmd [N_CMD];

    int errors = 0;
    int checks = 0;

    int          ob_we_cnt, ob_we_first, ob_upd_cnt;
    int          ob_done_cyc [$];
    logic [3:0]  ob_we_addr [$];
    logic [N_CMD-1:0] ob_upd_or;

    assign rdata  = mosi[addr];
    assign rdata2 = 32'h0;

    spi_reg_scanner #(.N_CMD(N_CMD), .N_STAT(N_STAT), .SCAN_DIV(50000)) dut (
        .Clk(clk), .Reset_n(rst_n), .Data_WE(we), .Data_Addr(addr), .Data_Write(wdata),
        .Data_Read(rdata), .Stat_In(stat), .Scan_Now(scan_now), .Freeze(freeze),
        .Cmd_Out(cmd), .Cmd_Update(upd), .Scan_Done(done)
    );

    spi_reg_scanner #(.N_CMD(N_CMD), .N_STAT(N_STAT), .SCAN_DIV(40)) dut_fast (
        .Clk(clk), .Reset_n(rst_n), .Data_WE(we2), .Data_Addr(addr2), .Data_Write(wdata2),
        .Data_Read(rdata2), .Stat_In(stat2), .Scan_Now(scan_now2), .Freeze(freeze2),
        .Cmd_Out(cmd2), .Cmd_Update(upd2), .Scan_Done(done2)
    );

    function automatic logic [N_STAT*32-1:0] rand_stat();
        logic [N_STAT*32-1:0] r;
        for (int j = 0; j < N_STAT; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    // Words whose mosi value differs from the model's shadow copy.
    function automatic logic [N_CMD-1:0] changed_mask();
        logic [N_CMD-1:0] m;
        for (int i = 0; i < N_CMD; i++) m[i] = (mosi[i] != exp_cmd[i]);
        return m;
    endfunction

    // Called on a falling edge: one-cycle request, pending latches, scan starts next edge.
    task automatic kick();
        scan_now = 1'b1;
        @(negedge clk);
        scan_now = 1'b0;
    endtask

    // Records bus activity; cycle 1 is the first cycle after the scan leaves IDLE.
    task automatic observe(input int ncyc, input int chg_stat_at, input int now_at);
        ob_we_cnt = 0; ob_we_first = -1; ob_upd_cnt = 0; ob_upd_or = '0;
        ob_done_cyc.delete();
        ob_we_addr.delete();
        for (int cc = 1; cc <= ncyc; cc++) begin
            @(negedge clk);
            if (we) begin
                ob_we_cnt++;
                if (ob_we_first < 0) ob_we_first = cc;
                ob_we_addr.push_back(addr);
                miso[addr] = wdata;
            end
            if (done) ob_done_cyc.push_back(cc);
            ob_upd_or  |= upd;
            ob_upd_cnt += $countones(upd);
            scan_now = (cc == now_at);
            if (cc == chg_stat_at) stat = rand_stat();
        end
        scan_now = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (we !== 1'b0)    begin errors++; $display("FAIL reset_we: got %b want 0", we); end
        checks++; if (addr !== 4'd0)  begin errors++; $display("FAIL reset_addr: got %h want 0", addr); end
        checks++; if (wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", wdata); end
        checks++; if (cmd !== '0)     begin errors++; $display("FAIL reset_cmd: got %h want 0", cmd); end
        checks++; if (upd !== '0)     begin errors++; $display("FAIL reset_upd: got %b want 0", upd); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    endtask

    task automatic test_freeze();
        int n_we = 0, n_done = 0, first_we = -1, done_at = -1, done_cnt = 0, we_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            n_we   += int'(we2);
            n_done += int'(done2);
        end
        checks++; if (n_we != 0)   begin errors++; $display("FAIL freeze_we: got %0d writes want 0", n_we); end
        checks++; if (n_done != 0) begin errors++; $display("FAIL freeze_done: got %0d scans want 0", n_done); end
        freeze2 = 1'b0;
        for (int cc = 1; cc <= SCAN_LEN + 1; cc++) begin
            @(negedge clk);
            if (we2) begin we_cnt++; if (first_we < 0) first_we = cc; end
            if (done2) begin done_cnt++; done_at = cc; end
        end
        freeze2 = 1'b1;
        checks++; if (first_we != N_CMD + 1) begin errors++; $display("FAIL freeze_start: first write cycle %0d want %0d", first_we, N_CMD + 1); end
        checks++; if (we_cnt != N_STAT) begin errors++; $display("FAIL freeze_we_cnt: got %0d want %0d", we_cnt, N_STAT); end
        checks++; if (done_cnt != 1 || done_at != SCAN_LEN) begin errors++; $display("FAIL freeze_scan: done count %0d at %0d want 1 at %0d", done_cnt, done_at, SCAN_LEN); end
    endtask

    task automatic test_first_scan();
        logic [N_CMD-1:0] mask;
        for (int i = 0; i < 16; i++) mosi[i] = 32'h0;
        mosi[0] = 32'h0000_00AA;
        mosi[3] = 32'hDEAD_BEEF;
        for (int j = 0; j < N_STAT; j++) stat[j*32 +: 32] = 32'h100 + j;
        mask = changed_mask();
        for (int i = 0; i < N_CMD; i++) exp_cmd[i] = mosi[i];
        kick();
        observe(SCAN_LEN + 2, 1, -1);
        checks++; if (cmd[31:0] !== 32'h0000_00AA) begin errors++; $display("FAIL first_word0: got %h want 000000aa", cmd[31:0]); end
        checks++; if (cmd[127:96] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL first_word3: got %h want deadbeef", cmd[127:96]); end
        for (int i = 0; i < N_CMD; i++) begin
            checks++; if (cmd[i*32 +: 32] !== exp_cmd[i]) begin errors++; $display("FAIL first_cmd[%0d]: got %h want %h", i, cmd[i*32 +: 32], exp_cmd[i]); end
        end
        checks++; if (ob_upd_or !== 8'h09 || ob_upd_cnt != $countones(mask)) begin errors++; $display("FAIL first_upd: got %b (%0d pulses) want 00001001 (2 pulses)", ob_upd_or, ob_upd_cnt); end
        checks++; if (ob_done_cyc.size() != 1 || ob_done_cyc[0] != SCAN_LEN) begin errors++; $display("FAIL first_done: %0d pulses, first at %0d want 1 at %0d", ob_done_cyc.size(), (ob_done_cyc.size() > 0) ? ob_done_cyc[0] : -1, SCAN_LEN); end
        checks++; if (ob_we_cnt != N_STAT || ob_we_first != N_CMD + 1) begin errors++; $display("FAIL first_we: %0d writes from cycle %0d want %0d from %0d", ob_we_cnt, ob_we_first, N_STAT, N_CMD + 1); end
        for (int j = 0; j < ob_we_addr.size(); j++) begin
            checks++; if (ob_we_addr[j] !== 4'(j)) begin errors++; $display("FAIL first_waddr[%0d]: got %0d want %0d", j, ob_we_addr[j], j); end
        end
        for (int j = 0; j < N_STAT; j++) begin
            checks++; if (miso[j] !== 32'h100 + j) begin errors++; $display("FAIL snapshot[%0d]: got %h want %h", j, miso[j], 32'h100 + j); end
        end
        checks++; if (addr !== 4'd0 || wdata !== 32'h107) begin errors++; $display("FAIL idle_hold: addr %h data %h want 0 / 00000107", addr, wdata); end
    endtask

    task automatic test_no_change();
        kick();
        observe(SCAN_LEN + 2, -1, -1);
        checks++; if (ob_upd_or !== '0 || ob_upd_cnt != 0) begin errors++; $display("FAIL nochange_upd: got %b (%0d pulses) want none", ob_upd_or, ob_upd_cnt); end
        checks++; if (ob_done_cyc.size() != 1 || ob_done_cyc[0] != SCAN_LEN) begin errors++; $display("FAIL nochange_done: %0d pulses want 1 at %0d", ob_done_cyc.size(), SCAN_LEN); end
    endtask

    task automatic test_random();
        logic [N_CMD-1:0]     mask;
        logic [N_STAT*32-1:0] snap;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 16; i++) if ($urandom_range(0, 1) == 1) mosi[i] = $urandom;
            stat = rand_stat();
            snap = stat;
            mask = changed_mask();
            for (int i = 0; i < N_CMD; i++) exp_cmd[i] = mosi[i];
            kick();
            observe(SCAN_LEN + 2, 2, -1);
            checks++; if (cmd !== {exp_cmd[7], exp_cmd[6], exp_cmd[5], exp_cmd[4], exp_cmd[3], exp_cmd[2], exp_cmd[1], exp_cmd[0]}) begin errors++; $display("FAIL rand%0d_cmd: got %h", it, cmd); end
            checks++; if (ob_upd_or !== mask || ob_upd_cnt != $countones(mask)) begin errors++; $display("FAIL rand%0d_upd: got %b (%0d pulses) want %b", it, ob_upd_or, ob_upd_cnt, mask); end
            for (int j = 0; j < N_STAT; j++) begin
                checks++; if (miso[j] !== snap[j*32 +: 32]) begin errors++; $display("FAIL rand%0d_miso[%0d]: got %h want %h", it, j, miso[j], snap[j*32 +: 32]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [N_STAT*32-1:0] snap;
        stat = rand_stat();
        snap = stat;
        kick();
        observe(2 * SCAN_LEN + 6, -1, N_CMD + 3);
        checks++; if (ob_done_cyc.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d scans want 2", ob_done_cyc.size()); end
        else begin
            checks++; if (ob_done_cyc[0] != SCAN_LEN || ob_done_cyc[1] != 2 * SCAN_LEN + 1) begin errors++; $display("FAIL b2b_timing: done at %0d,%0d want %0d,%0d", ob_done_cyc[0], ob_done_cyc[1], SCAN_LEN, 2 * SCAN_LEN + 1); end
        end
        checks++; if (ob_we_cnt != 2 * N_STAT) begin errors++; $display("FAIL b2b_we: got %0d writes want %0d", ob_we_cnt, 2 * N_STAT); end
        for (int j = 0; j < N_STAT; j++) begin
            checks++; if (miso[j] !== snap[j*32 +: 32]) begin errors++; $display("FAIL b2b_miso[%0d]: got %h want %h", j, miso[j], snap[j*32 +: 32]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [N_CMD-1:0] mask;
        for (int i = 0; i < 16; i++) mosi[i] = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
        mosi[1] = 32'h1234_5678;
        for (int i = 0; i < N_CMD; i++) exp_cmd[i] = mosi[i];
        kick();
        observe(N_CMD + 4, -1, -1);
        checks++; if (we !== 1'b1 || addr !== 4'd3) begin errors++; $display("FAIL mid_pre: we %b addr %h want 1 / 3", we, addr); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL mid_we: got %b want 0", we); end
        checks++; if (cmd !== '0 || upd !== '0) begin errors++; $display("FAIL mid_cmd: got %h / %b want 0", cmd, upd); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N_CMD; i++) exp_cmd[i] = 32'h0;
        observe(30, -1, -1);
        checks++; if (ob_we_cnt != 0 || ob_done_cyc.size() != 0) begin errors++; $display("FAIL mid_idle: %0d writes %0d scans want 0", ob_we_cnt, ob_done_cyc.size()); end
        mask = changed_mask();
        for (int i = 0; i < N_CMD; i++) exp_cmd[i] = mosi[i];
        kick();
        observe(SCAN_LEN + 2, -1, -1);
        checks++; if (ob_upd_or !== mask || ob_upd_cnt != $countones(mask)) begin errors++; $display("FAIL mid_rescan_upd: got %b want %b", ob_upd_or, mask); end
        checks++; if (cmd[63:32] !== 32'h1234_5678) begin errors++; $display("FAIL mid_rescan_word1: got %h want 12345678", cmd[63:32]); end
    endtask

    initial begin
        rst_n = 1'b0; scan_now = 1'b0; freeze = 1'b0; stat = '0;
        scan_now2 = 1'b0; freeze2 = 1'b1; stat2 = '0;
        for (int i = 0; i < 16; i++) begin mosi[i] = 32'h0; miso[i] = 32'h0; end
        for (int i = 0; i < N_CMD; i++) exp_cmd[i] = 32'h0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_freeze();
        test_first_scan();
        test_no_change();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
